bank_line_packer: RTL and testbench
===================================

# bank_line_packer

Upstream input stage for the day-3 joltage pipeline. It accepts the puzzle text as an ASCII byte stream with a valid/ready handshake and strips line terminators. It packs each battery bank (one text line of decimal digits) into a fixed-width record of 4-bit digits plus a length. Completed records go to the bank-scoring stage over a valid/ready handshake, so the scorer can read banks from a parser instead of a preloaded ROM.

## Interface

- `MAX_DIGITS`, default 100: maximum digits stored per bank.
- `LEN_W`, default 7: width of the length field; must satisfy 2^LEN_W > MAX_DIGITS.
- `clk` in, 1: single clock; all logic is on the rising edge.
- `rst_n` in, 1: reset, synchronous and active-low.
- `in_valid` in, 1: `in_byte` is valid this cycle.
- `in_ready` out, 1: the block can accept a byte this cycle.
- `in_byte` in, 8: ASCII byte.
- `in_last` in, 1: this byte is the final byte of the file. It ends the current line after the byte is processed.
- `out_valid` out, 1: a record is held on the output.
- `out_ready` in, 1: the consumer takes the record this cycle.
- `out_digits` out, 4*MAX_DIGITS: digit i occupies bits [4i+3:4i]; digit 0 is the leftmost character of the line.
- `out_len` out, LEN_W: number of valid digits, 1..MAX_DIGITS.
- `out_overflow` out, 1: the line contained more than MAX_DIGITS digits.
- `line_count` out, 16: number of records emitted since reset; wraps at 2^16.
- `err_count` out, 16: number of illegal bytes since reset; saturates at 0xFFFF.

## Operation

- A byte is transferred on a cycle where `in_valid` and `in_ready` are both high. A record is transferred on a cycle where `out_valid` and `out_ready` are both high.
- Two registers hold data:
  - The assembly register (`asm_digits`, `asm_len`, `asm_ovf`) builds the current line.
  - The output register drives the `out_*` ports.
- State machine states are FILL and HOLD. Reset enters FILL.
- In FILL, `in_ready` is 1. Each accepted byte is handled as follows:
  - `'0'`..`'9'` (0x30-0x39): if `asm_len < MAX_DIGITS`, write `byte - 0x30` at index `asm_len` and increment `asm_len`. Otherwise drop the digit and set `asm_ovf`.
  - `'\r'` (0x0D): ignored.
  - `'\n'` (0x0A): end of line.
  - Any other byte: ignored, and `err_count` increments.
  - If `in_last` is set, end of line is applied after the byte's own effect. A byte that is both `'\n'` and `in_last` produces a single end of line.
- End of line with `asm_len == 0` is discarded: no record is produced and no counter changes.
- End of line with `asm_len > 0`:
  - If the output slot is free this cycle (`out_valid == 0`, or `out_ready == 1`), the record is committed at this edge. The assembly register is cleared (digits zeroed, `len` 0, `ovf` 0) and `line_count` increments. The state stays FILL.
  - Otherwise the state goes to HOLD with the assembly contents kept, which now include the final byte.
- In HOLD, `in_ready` is 0. When the slot frees, the record is committed at that edge, the assembly register is cleared and the state returns to FILL.
- Record contents: digit positions at and above `out_len` in `out_digits` are always 0.
- Mid-operation reset: when `rst_n` is low at an edge, the partial line, any held record and both counters are discarded.

## Timing

- While `rst_n` is low, `in_ready` is 0.
- Reset values: `out_valid` 0, `out_digits` 0, `out_len` 0, `out_overflow` 0, `line_count` 0, `err_count` 0. `in_ready` is 1 from the first cycle after reset is released.
- Throughput is one byte per cycle in FILL.
- Latency: a record is visible with `out_valid` = 1 in the cycle after its terminating byte is accepted, provided the slot was free.
- `out_*` must remain stable while `out_valid && !out_ready`.
- Back-to-back terminators: when the slot is drained every cycle, records can be emitted on consecutive cycles, for example for lines "1\n2\n".
- `in_ready` is a decode of the state register only. It has no combinational path from `out_ready`, so HOLD exits one edge after `out_ready` is seen high.

## Structure

- Shared package `day3_pkg` holds:
  - `MAX_DIGITS` and `LEN_W` defaults.
  - ASCII constants `ASCII_0`, `ASCII_9`, `ASCII_LF`, `ASCII_CR`.
  - The state enum `{FILL, HOLD}`.
  - A packed `bank_rec_t` containing `digits`, `len` and `ovf`.
- No sub-module is needed. The byte classifier is a small function in `day3_pkg`.

## Test plan

1. Basic line: "987654321111111\n" with `out_ready` = 1 → one record with `out_len` 15 and digits 9,8,7,6,5,4,3,2,1,1,1,1,1,1,1. Digits 15..99 are 0, `out_overflow` 0, `line_count` 1, `err_count` 0.
2. Backpressure: `out_ready` = 0, send "12\n34\n" → first record {1,2} held. `in_ready` drops after the second `'\n'`. Raising `out_ready` delivers {1,2} then {3,4} in order, and `line_count` reaches 2.
3. Terminators: "5\r\n\n\n7\n" → exactly two records, {5} and {7}, with `err_count` 0.
4. Overflow: 102 × `'1'` then `'\n'` → `out_len` 100, all 100 digits equal 1, `out_overflow` 1. The next line "2\n" has `out_overflow` 0.
5. Illegal bytes and file end: "3a-4" with `in_last` on `'4'` → record {3,4} with `err_count` 2 and no extra record.
6. Reset: mid-line reset after "99", then "1\n" → record {1}, `line_count` 1. Reset while in HOLD → `out_valid` 0 and `in_ready` 1 on the first cycle after reset is released.

Source files
------------

// File: rtl/day3_pkg.sv
// Shared types and constants for the day-3 joltage pipeline: ASCII codes, packer FSM states,
// the bank record layout and the byte classifier used by the line packer.
package day3_pkg;

    localparam int DEF_MAX_DIGITS = 100;
    localparam int DEF_LEN_W      = 7;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    typedef enum logic {FILL, HOLD} state_t;

    typedef enum logic [1:0] {BYTE_DIGIT, BYTE_CR, BYTE_LF, BYTE_BAD} byte_cls_t;

    typedef struct packed {
        logic [4*DEF_MAX_DIGITS-1:0] digits;
        logic [DEF_LEN_W-1:0]        len;
        logic                        ovf;
    } bank_rec_t;

    function automatic byte_cls_t classify_byte(input logic [7:0] b);
        byte_cls_t cls;
        if (b >= ASCII_0 && b <= ASCII_9) begin
            cls = BYTE_DIGIT;
        end else if (b == ASCII_CR) begin
            cls = BYTE_CR;
        end else if (b == ASCII_LF) begin
            cls = BYTE_LF;
        end else begin
            cls = BYTE_BAD;
        end
        return cls;
    endfunction

endpackage

// File: rtl/bank_line_packer.sv
// Packs an ASCII digit stream into one fixed-width record per text line, with a one-deep
// output register and a HOLD state that stalls input while a finished line waits for the slot.
module bank_line_packer
    import day3_pkg::*;
#(
    parameter int MAX_DIGITS = DEF_MAX_DIGITS,
    parameter int LEN_W      = DEF_LEN_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_byte,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*MAX_DIGITS-1:0] out_digits,
    output logic [LEN_W-1:0]        out_len,
    output logic                    out_overflow,
    output logic [15:0]             line_count,
    output logic [15:0]             err_count
);

    state_t                  state_reg;
    logic                    ready_reg;
    logic [4*MAX_DIGITS-1:0] asm_digits_reg, asm_digits_next;
    logic [LEN_W-1:0]        asm_len_reg, asm_len_next;
    logic                    asm_ovf_reg, asm_ovf_next;
    logic                    out_valid_reg;
    logic [4*MAX_DIGITS-1:0] out_digits_reg;
    logic [LEN_W-1:0]        out_len_reg;
    logic                    out_ovf_reg;
    logic [15:0]             line_count_reg;
    logic [15:0]             err_count_reg;

    byte_cls_t cls;
    logic      accept, is_digit, has_room, eol, slot_free, fill_done, commit;
    logic [3:0] digit_val;

    assign cls       = classify_byte(in_byte);
    assign digit_val = 4'(in_byte - ASCII_0);
    assign accept    = in_valid && ready_reg;
    assign is_digit  = accept && (cls == BYTE_DIGIT);
    assign has_room  = asm_len_reg < LEN_W'(MAX_DIGITS);
    assign eol       = accept && ((cls == BYTE_LF) || in_last);
    assign slot_free = !out_valid_reg || out_ready;

    // Next assembly contents include the byte accepted this cycle, so a terminating
    // in_last digit lands in the same record it closes.
    generate
        for (genvar gi = 0; gi < MAX_DIGITS; gi++) begin : g_digit
            assign asm_digits_next[4*gi +: 4] =
                (is_digit && has_room && (asm_len_reg == LEN_W'(gi))) ? digit_val
                                                                      : asm_digits_reg[4*gi +: 4];
        end
    endgenerate

    assign asm_len_next = (is_digit && has_room) ? asm_len_reg + LEN_W'(1) : asm_len_reg;
    assign asm_ovf_next = asm_ovf_reg | (is_digit && !has_room);
    assign fill_done    = eol && (asm_len_next != '0);
    assign commit       = (state_reg == FILL) ? (fill_done && slot_free) : slot_free;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= FILL;
            ready_reg      <= 1'b0;
            asm_digits_reg <= '0;
            asm_len_reg    <= '0;
            asm_ovf_reg    <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_digits_reg <= '0;
            out_len_reg    <= '0;
            out_ovf_reg    <= 1'b0;
            line_count_reg <= '0;
            err_count_reg  <= '0;
        end else begin
            case (state_reg)
                FILL: begin
                    if (fill_done && !slot_free) begin
                        state_reg <= HOLD;
                        ready_reg <= 1'b0;
                    end else begin
                        ready_reg <= 1'b1;
                    end
                end
                HOLD: begin
                    if (slot_free) begin
                        state_reg <= FILL;
                        ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= FILL;
                    ready_reg <= 1'b1;
                end
            endcase

            if (commit) begin
                asm_digits_reg <= '0;
                asm_len_reg    <= '0;
                asm_ovf_reg    <= 1'b0;
                out_valid_reg  <= 1'b1;
                out_digits_reg <= asm_digits_next;
                out_len_reg    <= asm_len_next;
                out_ovf_reg    <= asm_ovf_next;
                line_count_reg <= line_count_reg + 16'd1;
            end else begin
                asm_digits_reg <= asm_digits_next;
                asm_len_reg    <= asm_len_next;
                asm_ovf_reg    <= asm_ovf_next;
                if (out_ready) begin
                    out_valid_reg <= 1'b0;
                end
            end

            if (accept && (cls == BYTE_BAD) && (err_count_reg != 16'hFFFF)) begin
                err_count_reg <= err_count_reg + 16'd1;
            end
        end
    end

    assign in_ready     = ready_reg;
    assign out_valid    = out_valid_reg;
    assign out_digits   = out_digits_reg;
    assign out_len      = out_len_reg;
    assign out_overflow = out_ovf_reg;
    assign line_count   = line_count_reg;
    assign err_count    = err_count_reg;

endmodule

// File: tb/tb_bank_line_packer.sv
// Directed bench for bank_line_packer: a vector table of whole-file inputs plus hand-written
// sequences for backpressure, overflow and reset.
module tb_bank_line_packer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_byte;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [399:0] out_digits;
    logic [6:0]   out_len;
    logic         out_overflow;
    logic [15:0]  line_count;
    logic [15:0]  err_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [399:0] digits;
        logic [6:0]   len;
        logic         ovf;
    } rec_t;

    rec_t q[$];

    typedef struct {
        string text;
        bit    last;
        int    nrec;
        string r0;
        string r1;
        int    lines;
        int    errs;
    } vec_t;

    vec_t vecs[6];

    bank_line_packer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_byte      (in_byte),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_digits   (out_digits),
        .out_len      (out_len),
        .out_overflow (out_overflow),
        .line_count   (line_count),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin : mon
        rec_t r;
        if (rst_n && out_valid && out_ready) begin
            r.digits = out_digits;
            r.len    = out_len;
            r.ovf    = out_overflow;
            q.push_back(r);
            $display("record len=%0d ovf=%0d line_count=%0d", out_len, out_overflow, line_count);
        end
    end

    function automatic logic [399:0] exp_digits(input string s);
        logic [399:0] d = '0;
        for (int i = 0; i < s.len(); i++) begin
            d[4*i +: 4] = 4'(s[i] - 8'h30);
        end
        return d;
    endfunction

    task automatic chk(input string name, input logic [399:0] act, input logic [399:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rec(input string name, input string exp, input bit exp_ovf);
        rec_t r;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: got no record expected digits %s", name, exp);
        end else begin
            r = q.pop_front();
            chk({name, ".len"}, 400'(r.len), 400'(exp.len()));
            chk({name, ".digits"}, r.digits, exp_digits(exp));
            chk({name, ".ovf"}, 400'(r.ovf), 400'(exp_ovf));
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last);
        int waited = 0;
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = last;
        while (!ok && waited < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            waited++;
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_byte: got in_ready=0 for 50 cycles expected acceptance of %0h", b);
        end
    endtask

    task automatic send_str(input string s, input bit last_on_final);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], last_on_final && (i == s.len() - 1));
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        string s100;

        vecs[0] = '{"987654321111111\n", 1'b0, 1, "987654321111111", "", 1, 0};
        vecs[1] = '{"5\015\n\n\n7\n",    1'b0, 2, "5", "7", 2, 0};
        vecs[2] = '{"3a-4",               1'b1, 1, "34", "", 1, 2};
        vecs[3] = '{"1\n2\n",             1'b0, 2, "1", "2", 2, 0};
        vecs[4] = '{"\n\015\n",           1'b0, 0, "", "", 0, 0};
        vecs[5] = '{"12\n",               1'b1, 1, "12", "", 1, 0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.in_ready", 400'(in_ready), 400'(0));
        chk("rst.out_valid", 400'(out_valid), 400'(0));
        chk("rst.out_digits", out_digits, '0);
        chk("rst.out_len", 400'(out_len), 400'(0));
        chk("rst.out_overflow", 400'(out_overflow), 400'(0));
        chk("rst.line_count", 400'(line_count), 400'(0));
        chk("rst.err_count", 400'(err_count), 400'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst.in_ready_after", 400'(in_ready), 400'(1));

        for (int v = 0; v < 6; v++) begin
            do_reset();
            out_ready = 1'b1;
            send_str(vecs[v].text, vecs[v].last);
            drain();
            $display("vector %0d records=%0d line_count=%0d err_count=%0d",
                     v, q.size(), line_count, err_count);
            chk($sformatf("vec%0d.nrec", v), 400'(q.size()), 400'(vecs[v].nrec));
            if (vecs[v].nrec >= 1) chk_rec($sformatf("vec%0d.rec0", v), vecs[v].r0, 1'b0);
            if (vecs[v].nrec >= 2) chk_rec($sformatf("vec%0d.rec1", v), vecs[v].r1, 1'b0);
            chk($sformatf("vec%0d.line_count", v), 400'(line_count), 400'(vecs[v].lines));
            chk($sformatf("vec%0d.err_count", v), 400'(err_count), 400'(vecs[v].errs));
        end

        // Backpressure: second line must wait in HOLD behind the first.
        do_reset();
        out_ready = 1'b0;
        send_str("12\n", 1'b0);
        @(negedge clk);
        chk("bp.latency_valid", 400'(out_valid), 400'(1));
        chk("bp.latency_len", 400'(out_len), 400'(2));
        @(posedge clk);
        #1;
        send_str("34\n", 1'b0);
        @(negedge clk);
        chk("bp.in_ready_low", 400'(in_ready), 400'(0));
        repeat (3) @(negedge clk);
        chk("bp.stable_digits", out_digits, exp_digits("12"));
        chk("bp.still_held", 400'(in_ready), 400'(0));
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();
        $display("backpressure records=%0d line_count=%0d", q.size(), line_count);
        chk("bp.nrec", 400'(q.size()), 400'(2));
        chk_rec("bp.rec0", "12", 1'b0);
        chk_rec("bp.rec1", "34", 1'b0);
        chk("bp.line_count", 400'(line_count), 400'(2));
        chk("bp.in_ready_back", 400'(in_ready), 400'(1));

        // Overflow: 102 digits keep the first 100 and flag the line.
        do_reset();
        out_ready = 1'b1;
        s100 = "";
        for (int i = 0; i < 100; i++) s100 = {s100, "1"};
        for (int i = 0; i < 102; i++) send_byte(8'h31, 1'b0);
        send_byte(8'h0A, 1'b0);
        send_str("2\n", 1'b0);
        drain();
        $display("overflow records=%0d", q.size());
        chk("ovf.nrec", 400'(q.size()), 400'(2));
        chk_rec("ovf.rec0", s100, 1'b1);
        chk_rec("ovf.rec1", "2", 1'b0);

        // Reset mid-line discards the partial line.
        do_reset();
        out_ready = 1'b1;
        send_str("99", 1'b0);
        do_reset();
        out_ready = 1'b1;
        send_str("1\n", 1'b0);
        drain();
        $display("midline reset records=%0d line_count=%0d", q.size(), line_count);
        chk("rst_mid.nrec", 400'(q.size()), 400'(1));
        chk_rec("rst_mid.rec0", "1", 1'b0);
        chk("rst_mid.line_count", 400'(line_count), 400'(1));

        // Reset while a record is held.
        do_reset();
        out_ready = 1'b0;
        send_str("1\n2\n", 1'b0);
        @(negedge clk);
        chk("rst_hold.in_hold", 400'(in_ready), 400'(0));
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold.in_ready_in_reset", 400'(in_ready), 400'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        $display("hold reset out_valid=%0d in_ready=%0d", out_valid, in_ready);
        chk("rst_hold.out_valid", 400'(out_valid), 400'(0));
        chk("rst_hold.in_ready", 400'(in_ready), 400'(1));
        chk("rst_hold.line_count", 400'(line_count), 400'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
